// File: rtl/jesd204_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_pkg
// Purpose  : Shared types and constants for the JESD204B receive link layer:
//            CGS state encodings, control-character codes and the CGS
//            character-count thresholds.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jesd204_pkg;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd1,
    CS_CHECK = 2'd2,
    CS_DATA  = 2'd3
  } cgs_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start (ILA begin)

  // Widths are chosen so every comparison against the counters is exact-width.
  localparam logic [2:0] CGS_K_MIN       = 3'd4;
  localparam logic [1:0] CGS_INVALID_MAX = 2'd3;
  localparam logic [2:0] CGS_VALID_CLR   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/jesd204_rx_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_rx_sync_if
// Purpose  : Decoded 8b/10b octet stream from the lane decoder to the
//            receive link controller.
// Signals  : octet[7:0] decoded octet, is_k control character flag,
//            disp_err running disparity error, nit_err not-in-table error.
// Modports : master (decoder side, drives), slave (link controller, reads)
// Revision : 1.0 - initial release
// ============================================================================
interface jesd204_rx_sync_if;
  logic [7:0] octet;
  logic       is_k;
  logic       disp_err;
  logic       nit_err;

  modport master (output octet, output is_k, output disp_err, output nit_err);
  modport slave  (input  octet, input  is_k, input  disp_err, input  nit_err);
endinterface
`default_nettype wire

// File: rtl/jesd204_rx_err_report.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_rx_err_report
// Purpose  : SYNC~ error-report stretcher. A trigger pulls report_n low from
//            the next cycle until the cycle after the second frame_clk pulse
//            that follows the trigger. Triggers during an active report are
//            ignored; clear aborts the report immediately.
// Ports    : clk, rst_n (async, active-low), frame_clk (frame pulse),
//            clear (link re-init), trigger (reportable error),
//            report_n (active-low report, ANDed into SYNC~)
// Revision : 1.0 - initial release
// ============================================================================
module jesd204_rx_err_report (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic frame_clk,
  input  wire logic clear,
  input  wire logic trigger,
  output logic      report_n
);

  logic r_active;
  logic r_fcnt;    // frame pulses seen since the trigger (0 or 1)

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_fcnt   <= 1'b0;
    end else if (clear) begin
      r_active <= 1'b0;
      r_fcnt   <= 1'b0;
    end else if (!r_active) begin
      // A frame pulse coinciding with the trigger is not "subsequent".
      r_fcnt <= 1'b0;
      if (trigger) begin
        r_active <= 1'b1;
      end
    end else if (frame_clk) begin
      if (r_fcnt) begin
        r_active <= 1'b0;
        r_fcnt   <= 1'b0;
      end else begin
        r_fcnt <= 1'b1;
      end
    end
  end

  assign report_n = ~r_active;

endmodule
`default_nettype wire

// File: rtl/jesd204_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : jesd204_rx_sync
// Purpose  : JESD204B receive link-layer controller for one lane. Runs code
//            group synchronization, releases SYNC~ on an LMFC boundary,
//            detects ILA start (/R/), times the ILA length in multiframes,
//            flags user data valid and re-initializes on character errors.
// Ports    : clk, rst_n (async, active-low), frame_clk, lmfc_clk (pulses),
//            i_link_en, rx (octet stream, slave modport),
//            i_ila_multiframe_length (multiframes - 1),
//            o_sync_n, o_cgs_state, o_ila_start, o_ila_err, o_data_valid,
//            o_err_cnt (saturating, cleared only by reset)
// Options  : JESD_RX_ERR_REPORT_EN - report CS_DATA character errors on SYNC~
// Revision : 1.0 - initial release
// ============================================================================
module jesd204_rx_sync
  import jesd204_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        frame_clk,
  input  wire logic        lmfc_clk,
  input  wire logic        i_link_en,
  jesd204_rx_sync_if.slave rx,
  input  wire logic [7:0]  i_ila_multiframe_length,
  output logic             o_sync_n,
  output logic [1:0]       o_cgs_state,
  output logic             o_ila_start,
  output logic             o_ila_err,
  output logic             o_data_valid,
  output logic [7:0]       o_err_cnt
);

  cgs_state_t r_state;
  logic [2:0] r_kcnt;
  logic [1:0] r_icnt;
  logic [2:0] r_vcnt;
  logic [8:0] r_ila_cnt;
  logic       r_sync_n;
  logic       r_data_valid;
  logic       r_ila_start;
  logic       r_ila_err;
  logic [7:0] r_err_cnt;

  logic       w_invalid;
  logic       w_is_kchar;
  logic       w_is_r;
  logic [2:0] w_kcnt_nxt;
  logic [1:0] w_icnt_nxt;
  logic [2:0] w_vcnt_nxt;
  logic [8:0] w_ila_nxt;
  logic [8:0] w_ila_target;
  logic       w_err_hit;
  logic       w_ila_err;
  logic       w_reinit;
  logic       w_report_n;

  // Character classification
  assign w_invalid  = rx.disp_err | rx.nit_err;
  assign w_is_kchar = ~w_invalid & rx.is_k & (rx.octet == K28_5);
  assign w_is_r     = ~w_invalid & rx.is_k & (rx.octet == K28_0);

  assign w_kcnt_nxt   = r_kcnt + 3'd1;
  assign w_icnt_nxt   = r_icnt + 2'd1;
  assign w_vcnt_nxt   = r_vcnt + 3'd1;
  assign w_ila_nxt    = r_ila_cnt + 9'd1;
  assign w_ila_target = {1'b0, i_ila_multiframe_length} + 9'd1;

  // Third invalid character without an intervening run of valid ones.
  assign w_err_hit = w_invalid && (r_state != CS_INIT) && (w_icnt_nxt == CGS_INVALID_MAX);

  // SYNC~ is already released, so this is the first valid non-/K/ and it is
  // not /R/: the ILA did not start correctly.
  assign w_ila_err = (r_state == CS_CHECK) && r_sync_n && !w_invalid && !w_is_kchar && !w_is_r;

  // Any cause of a return to CS_INIT; it outranks SYNC~ release and /R/.
  assign w_reinit = !i_link_en || w_err_hit || w_ila_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CS_INIT;
      r_kcnt       <= 3'd0;
      r_icnt       <= 2'd0;
      r_vcnt       <= 3'd0;
      r_ila_cnt    <= 9'd0;
      r_sync_n     <= 1'b0;
      r_data_valid <= 1'b0;
      r_ila_start  <= 1'b0;
      r_ila_err    <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_ila_start <= 1'b0;
      r_ila_err   <= 1'b0;

      // Error counting covers the re-init character too.
      if ((r_state == CS_DATA) && w_invalid && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (w_reinit) begin
        r_state      <= CS_INIT;
        r_kcnt       <= 3'd0;
        r_icnt       <= 2'd0;
        r_vcnt       <= 3'd0;
        r_ila_cnt    <= 9'd0;
        r_sync_n     <= 1'b0;
        r_data_valid <= 1'b0;
        r_ila_err    <= i_link_en & w_ila_err;
      end else begin
        case (r_state)
          CS_INIT: begin
            if (w_is_kchar) begin
              if (w_kcnt_nxt == CGS_K_MIN) begin
                r_state <= CS_CHECK;
                r_kcnt  <= 3'd0;
                r_icnt  <= 2'd0;
                r_vcnt  <= 3'd0;
              end else begin
                r_kcnt <= w_kcnt_nxt;
              end
            end else begin
              r_kcnt <= 3'd0;
            end
          end

          CS_CHECK, CS_DATA: begin
            // Invalid/valid windowing shared by both states.
            if (w_invalid) begin
              r_icnt <= w_icnt_nxt;
              r_vcnt <= 3'd0;
            end else if (w_vcnt_nxt == CGS_VALID_CLR) begin
              r_icnt <= 2'd0;
              r_vcnt <= 3'd0;
            end else begin
              r_vcnt <= w_vcnt_nxt;
            end

            if (r_state == CS_CHECK) begin
              // The /R/ check uses the registered SYNC~, so an octet in the
              // release cycle is never examined.
              if (!r_sync_n) begin
                if (lmfc_clk) begin
                  r_sync_n <= 1'b1;
                end
                if (!w_invalid && !w_is_kchar) begin
                  r_kcnt <= 3'd0;
                end
              end else if (w_is_r) begin
                r_state      <= CS_DATA;
                r_ila_start  <= 1'b1;
                r_ila_cnt    <= 9'd0;
                r_data_valid <= 1'b0;
              end
            end else if (!r_data_valid && lmfc_clk) begin
              // Counter freezes once data is valid, so it never wraps.
              r_ila_cnt <= w_ila_nxt;
              if (w_ila_nxt == w_ila_target) begin
                r_data_valid <= 1'b1;
              end
            end
          end

          default: begin
            r_state  <= CS_INIT;
            r_kcnt   <= 3'd0;
            r_icnt   <= 2'd0;
            r_vcnt   <= 3'd0;
            r_sync_n <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JESD_RX_ERR_REPORT_EN
  logic w_report_trig;

  // Only errors that do not themselves force re-init are reported.
  assign w_report_trig = i_link_en && (r_state == CS_DATA) && w_invalid && !w_err_hit;

  jesd204_rx_err_report u_err_report (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_clk (frame_clk),
    .clear     (w_reinit),
    .trigger   (w_report_trig),
    .report_n  (w_report_n)
  );
`else
  logic w_unused_frame_clk;

  assign w_unused_frame_clk = frame_clk;
  assign w_report_n         = 1'b1;
`endif

  assign o_sync_n     = r_sync_n & w_report_n;
  assign o_cgs_state  = r_state;
  assign o_ila_start  = r_ila_start;
  assign o_ila_err    = r_ila_err;
  assign o_data_valid = r_data_valid;
  assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/jesd204_rx_sync.md
# jesd204_rx_sync

Receive-side JESD204B link-layer controller for one lane: the counterpart of the transmit link controller. It runs code group synchronization (CGS) on decoded 8b/10b octets and drives SYNC~ back to the transmitter, aligning SYNC~ de-assertion to the LMFC boundary. It detects the start of the initial lane alignment (ILA) sequence and tracks the ILA length in multiframes. It then flags user data as valid and re-initializes the link on repeated character errors. It sits between the 8b/10b decoder and the lane alignment / descrambler path.

## Interface
- No parameters; all thresholds are package constants.
- clk  in  1  device clock, one decoded octet per cycle
- rst_n  in  1  reset; asynchronous, active-low
- frame_clk  in  1  one-cycle pulse at each frame boundary
- lmfc_clk  in  1  one-cycle pulse at each multiframe (LMFC) boundary
- i_link_en  in  1  low forces CS_INIT synchronously
- i_octet  in  8  decoded octet
- i_is_k  in  1  octet is a control character
- i_disp_err  in  1  running disparity error on this octet
- i_nit_err  in  1  not-in-table error on this octet
- i_ila_multiframe_length  in  8  ILA length; encoded as multiframes − 1
- o_sync_n  out  1  SYNC~ to transmitter, active-low; reset 0
- o_cgs_state  out  2  1=CS_INIT, 2=CS_CHECK, 3=CS_DATA; reset 1
- o_ila_start  out  1  one-cycle pulse when /R/ starts ILA; reset 0
- o_ila_err  out  1  one-cycle pulse when the first non-/K/ is not /R/; reset 0
- o_data_valid  out  1  user data phase active; reset 0
- o_err_cnt  out  8  saturating count of invalid characters seen in CS_DATA; reset 0, cleared only by reset

## Operation
Character classes:
- Invalid: i_disp_err or i_nit_err is set.
- /K/: valid, i_is_k=1, i_octet=8'hBC.
- /R/: valid, i_is_k=1, i_octet=8'h1C.

CS_INIT:
- o_sync_n=0.
- kcnt counts consecutive /K/; any other octet clears kcnt.
- On the 4th consecutive /K/, go to CS_CHECK.

CS_CHECK:
- o_sync_n stays 0 until the first lmfc_clk pulse seen while in CS_CHECK, then goes 1.
- Invalid character: icnt++ and vcnt is cleared.
- Valid character: vcnt++. When vcnt reaches 4, clear icnt and vcnt.
- When icnt reaches 3, go to CS_INIT.
- With o_sync_n=1, the first valid non-/K/ octet ends CS_CHECK:
  - /R/: go to CS_DATA and pulse o_ila_start.
  - Anything else: go to CS_INIT and pulse o_ila_err.
- Valid non-/K/ octets received while o_sync_n=0 clear kcnt-equivalent progress only; they do not leave CS_CHECK.

CS_DATA:
- Same icnt/vcnt rule as CS_CHECK; 3 invalid characters go to CS_INIT.
- Each invalid character increments o_err_cnt, which saturates at 255.
- ILA counter (9 bits) counts lmfc_clk pulses from entry to CS_DATA.
- o_data_valid goes 1 after (i_ila_multiframe_length + 1) pulses.

Entry to CS_INIT (any cause) clears kcnt, icnt, vcnt, the ILA counter and o_data_valid, and sets o_sync_n=0.

## Timing
- All outputs are registered; each reacts one cycle after the causing input or pulse.
- Priority, highest first: i_link_en=0 > reset-to-CS_INIT by error > lmfc-driven SYNC~ release > /R/ detection.
- The 3rd invalid character arriving in the same cycle as an lmfc_clk pulse in CS_CHECK: go to CS_INIT and o_sync_n stays 0.
- An octet arriving in the same cycle o_sync_n rises is not checked for /R/. The check starts the following cycle.
- An lmfc_clk pulse in the same cycle as /R/ is not counted toward ILA length.
- The ILA counter does not wrap; it holds once o_data_valid=1.
- When rst_n is asserted mid-operation, all outputs immediately return to their reset values.

## Configuration
- JESD_RX_ERR_REPORT_EN defined:
  - In CS_DATA, an invalid character that does not trigger re-init drives o_sync_n=0 starting the next cycle.
  - o_sync_n returns to 1 the cycle after the 2nd subsequent frame_clk pulse.
  - Errors occurring during an active report neither extend nor restart it.
  - Re-init to CS_INIT overrides the report.
- JESD_RX_ERR_REPORT_EN undefined: o_sync_n stays 1 throughout CS_DATA; errors are only counted.

## Structure
- Package jesd204_pkg holds:
  - CGS state encodings: CS_INIT=2'd1, CS_CHECK=2'd2, CS_DATA=2'd3.
  - K28_5=8'hBC and K28_0=8'h1C.
  - Thresholds: CGS_K_MIN=4, CGS_INVALID_MAX=3, CGS_VALID_CLR=4.
- Sub-module jesd204_rx_err_report is the SYNC~ pulse stretcher (frame pulse counter). It is instantiated only under JESD_RX_ERR_REPORT_EN and its output is ANDed into o_sync_n.

## Test plan
- **CGS and ILA entry.** After reset, send 4×/K/, then an lmfc pulse, then /R/.
  - o_cgs_state goes 1→2→3.
  - o_sync_n rises 1 cycle after the lmfc pulse.
  - o_ila_start pulses once.
- **ILA length.** With i_ila_multiframe_length=3 after /R/: o_data_valid rises 1 cycle after the 4th lmfc pulse.
- **K-run break.** Send 3×/K/, 1 data octet, then 4×/K/: CS_CHECK is entered only after the second run.
- **Error re-init.** In CS_DATA, send 3 invalid characters interleaved with fewer than 4 valid octets.
  - Go to CS_INIT, o_sync_n=0, o_data_valid=0, o_err_cnt=3.
- **Error threshold clear.** In CS_DATA, send 2 invalid, then 4 valid, then 2 invalid: no re-init, o_err_cnt=4.
- **Error report (with JESD_RX_ERR_REPORT_EN).** A single invalid character in CS_DATA gives o_sync_n low for exactly 2 frame_clk periods. A second error during that window does not extend it.
